// File: rtl/array_bubble_pass_if.sv
// Port bundle between the bubble-pass sequencer, the sort checker and the shared array memory.
// The slave modport is the sequencer; the master side is the surrounding system.
interface array_bubble_pass_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic [ADDR_W:0]   length;
  logic              check_go;
  logic              check_done;
  logic              check_sorted;
  logic              pass_active;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic              sorted;
  logic              error;
  logic [7:0]        pass_count;

  modport master (
    output start, length, check_done, check_sorted, mem_rdata,
    input  check_go, pass_active, mem_addr, mem_wdata, mem_we,
    input  busy, done, sorted, error, pass_count
  );

  modport slave (
    input  start, length, check_done, check_sorted, mem_rdata,
    output check_go, pass_active, mem_addr, mem_wdata, mem_we,
    output busy, done, sorted, error, pass_count
  );
endinterface

// File: rtl/array_bubble_pass.sv
// Runs in-place bubble-sort passes over a shared array until the external checker reports
// the array sorted, or the pass limit is reached. All outputs are registered.
module array_bubble_pass #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_PASSES = 32
) (
  input logic               clock,
  input logic               reset,
  array_bubble_pass_if.slave bus
);

  localparam logic [7:0]    MaxPasses = 8'(MAX_PASSES);
  localparam logic [ADDR_W:0] IdxOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] IdxTwo  = (ADDR_W + 1)'(2);

  typedef enum logic [3:0] {
    StIdle, StCheck, StWait, StLoad0, StRead, StSwapLo, StSwapHi, StDone, StError
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   i_q, i_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [7:0]        pc_q, pc_d;
  logic              advance;
  logic              last_pair;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  // Compare rather than equate so a bogus short length can never run away.
  assign last_pair = (i_q + IdxTwo) >= len_q;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    len_d   = len_q;
    a_d     = a_q;
    b_d     = b_q;
    pc_d    = pc_q;
    advance = 1'b0;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (bus.start) begin
          len_d   = bus.length;
          pc_d    = '0;
          state_d = StCheck;
        end
      end
      StCheck: state_d = StWait;
      StWait: begin
        if (bus.check_done) begin
          if (bus.check_sorted) begin
            state_d = StDone;
          end else if (pc_q == MaxPasses) begin
            state_d = StError;
          end else begin
            i_d     = '0;
            state_d = StLoad0;
          end
        end
      end
      StLoad0: begin
        a_d     = bus.mem_rdata;
        state_d = StRead;
      end
      StRead: begin
        if ($signed(a_q) > $signed(bus.mem_rdata)) begin
          b_d     = bus.mem_rdata;
          state_d = StSwapLo;
        end else begin
          a_d     = bus.mem_rdata;
          advance = 1'b1;
        end
      end
      StSwapLo: state_d = StSwapHi;
      // a_q keeps the running maximum, which now sits at i+1.
      StSwapHi: advance = 1'b1;
      default:  state_d = StIdle;
    endcase

    if (advance) begin
      if (last_pair) begin
        pc_d    = pc_q + 8'd1;
        state_d = StCheck;
      end else begin
        i_d     = i_q + IdxOne;
        state_d = StRead;
      end
    end
  end

  // Outputs are decoded from the next state so they are valid for the whole cycle.
  always_comb begin
    addr_d  = '0;
    wdata_d = '0;
    unique case (state_d)
      StRead: addr_d = i_d[ADDR_W-1:0] + ADDR_W'(1);
      StSwapLo: begin
        addr_d  = i_d[ADDR_W-1:0];
        wdata_d = b_d;
      end
      StSwapHi: begin
        addr_d  = i_d[ADDR_W-1:0] + ADDR_W'(1);
        wdata_d = a_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      i_q             <= '0;
      len_q           <= '0;
      a_q             <= '0;
      b_q             <= '0;
      pc_q            <= '0;
      bus.check_go    <= 1'b0;
      bus.pass_active <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_we      <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.sorted      <= 1'b0;
      bus.error       <= 1'b0;
    end else begin
      state_q         <= state_d;
      i_q             <= i_d;
      len_q           <= len_d;
      a_q             <= a_d;
      b_q             <= b_d;
      pc_q            <= pc_d;
      bus.check_go    <= (state_d == StCheck);
      bus.pass_active <= state_d inside {StLoad0, StRead, StSwapLo, StSwapHi};
      bus.mem_addr    <= addr_d;
      bus.mem_wdata   <= wdata_d;
      bus.mem_we      <= state_d inside {StSwapLo, StSwapHi};
      bus.busy        <= state_d inside {StCheck, StWait, StLoad0, StRead, StSwapLo, StSwapHi};
      bus.done        <= state_d inside {StDone, StError};
      bus.sorted      <= (state_d == StDone);
      bus.error       <= (state_d == StError);
    end
  end

  assign bus.pass_count = pc_q;

endmodule
